mem_matrix_seq: RTL and testbench
=================================

Name: mem_matrix_seq

Overview:
- MEM-stage sequencer that consumes the EX/MEM pipeline-register outputs for matrix memory instructions.
- Matrix store (matrix2mem): breaks one MAT_DIM-word matrix row into sequential word writes to data memory.
- Matrix load (mem2matrix): performs MAT_DIM word reads, packs them into one line and writes it into the matrix register file.
- Stalls the pipeline while a transfer is in flight.

Parameters:
- XLEN, 32, data word width in bits.
- MAT_DIM, 4, words per matrix row (power of two, ≥2).
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous reset, active-high.
- start_store  in  1  from me_matrix2mem; request a row store.
- start_load  in  1  from me_mem2matrix; request a row load.
- base_addr  in  ADDR_W  from me_alu_o; byte address of word 0.
- row_index  in  2  from me_matrix_index; target/source matrix row.
- store_line  in  MAT_DIM*XLEN  row data to store; word k = bits [XLEN*k+XLEN-1 : XLEN*k].
- mem_req  out  1  memory access request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  XLEN  write data.
- mem_ready  in  1  access completes in any cycle where mem_req && mem_ready.
- mem_rdata  in  XLEN  read data, valid in the completing cycle.
- stall  out  1  freeze IF/ID/EX and the EX/MEM register.
- busy  out  1  FSM not IDLE.
- mat_wr_en  out  1  one-cycle matrix-row write strobe.
- mat_wr_index  out  2  row written.
- mat_wr_line  out  MAT_DIM*XLEN  packed loaded row.
- done  out  1  one-cycle completion pulse.

Behaviour:
- States: IDLE, STORE, LOAD, DONE.
- Word counter cnt, $clog2(MAT_DIM) bits.
- IDLE:
  - start_store=1 → latch base_addr (low 2 bits forced to 0), row_index and store_line; cnt=0; go to STORE.
  - Otherwise start_load=1 → latch the same fields; go to LOAD.
  - If both starts are high, store has priority and the load is dropped.
- STORE:
  - mem_req=1, mem_we=1, mem_addr=base+4*cnt (modulo 2^ADDR_W, wraps), mem_wdata=word cnt of the latched line.
  - On each completion: cnt++. After word MAT_DIM-1 completes → DONE.
- LOAD:
  - mem_req=1, mem_we=0, mem_addr as in STORE.
  - On each completion: mem_rdata is captured into word cnt of the line buffer; cnt++.
  - After the last word completes → DONE.
- DONE (one cycle):
  - done=1.
  - If the transfer was a load: mat_wr_en=1, mat_wr_index=latched row, mat_wr_line=buffer. mat_wr_en is never asserted for a store.
  - Go to IDLE.
- Starts are ignored in DONE so held EX/MEM values cannot retrigger; the pipeline advances on the DONE→IDLE edge.
- stall is combinational: high when (IDLE && (start_store || start_load)) or state ∈ {STORE, LOAD}; low in DONE.
- busy = (state != IDLE).
- mem_ready low holds mem_addr, mem_wdata and cnt stable; wait states are unbounded.
- Latency with mem_ready tied high: start in cycle 0, accesses in cycles 1..MAT_DIM, done in cycle MAT_DIM+1.
- Outside their active state, mem_req, mem_we, mat_wr_en and done are 0.
- Reset values: mem_req, mem_we, mem_addr, mem_wdata, busy, mat_wr_en, mat_wr_index, mat_wr_line, done = 0; state = IDLE; cnt = 0; line buffer = 0.
- stall evaluates to 0 when starts are low.
- rst mid-transfer: aborts on the next edge. No matrix write and no done pulse; partial memory writes already completed stand.

Test Plan:
- Store, mem_ready=1, base=0x100, row=2, words 0x11,0x22,0x33,0x44 → writes 0x100/0x11, 0x104/0x22, 0x108/0x33, 0x10C/0x44 in cycles 1-4; done in cycle 5; stall high cycles 0-4; no mat_wr_en.
- Load, base=0x200, row=1, rdata 0xA0..0xA3 → reads 0x200..0x20C; DONE cycle has mat_wr_en=1, index=1, line={0xA3,0xA2,0xA1,0xA0}.
- Load with mem_ready low for 3 cycles on word 2 → mem_addr holds 0x208 and stall stays high; line still correct; done in cycle 8.
- start_store and start_load both high → only writes issued, no mat_wr_en; base=0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
- start held high through DONE → exactly one transfer and one done pulse; base=0x103 → first address 0x100.
- rst asserted after word 1 of a load → next cycle mem_req=0, busy=0, stall=0 (starts low), no mat_wr_en, no done.

Source files
------------

// File: rtl/mem_matrix_seq.sv
// MEM-stage sequencer for matrix row transfers.
// A row store is split into MAT_DIM word writes to data memory. A row load
// collects MAT_DIM word reads into one line and writes it to the matrix
// register file. The pipeline is stalled while a transfer is in flight.
module mem_matrix_seq #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned MAT_DIM = 4,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start_store,
   input  logic                    start_load,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [1:0]              row_index,
   input  logic [MAT_DIM*XLEN-1:0] store_line,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [XLEN-1:0]         mem_wdata,
   input  logic                    mem_ready,
   input  logic [XLEN-1:0]         mem_rdata,
   output logic                    stall,
   output logic                    busy,
   output logic                    mat_wr_en,
   output logic [1:0]              mat_wr_index,
   output logic [MAT_DIM*XLEN-1:0] mat_wr_line,
   output logic                    done
);

   localparam int unsigned CNT_W  = $clog2(MAT_DIM);
   localparam int unsigned LINE_W = MAT_DIM * XLEN;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_STORE = 2'd1,
      S_LOAD  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q;
   state_t              state_d;
   logic [CNT_W-1:0]    cnt_q;
   logic [ADDR_W-1:0]   base_q;
   logic [1:0]          row_q;
   logic [LINE_W-1:0]   line_q;
   logic                load_q;

   logic                active_c;
   logic                xfer_c;
   logic                last_c;

   assign active_c = (state_q == S_STORE) || (state_q == S_LOAD);
   assign xfer_c   = active_c && mem_ready;
   assign last_c   = (cnt_q == CNT_W'(MAT_DIM - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; store wins when both starts arrive together.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_store)     state_d = S_STORE;
            else if (start_load) state_d = S_LOAD;
         end
         S_STORE, S_LOAD: begin
            if (xfer_c && last_c) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Transfer context: request fields latched at start, word counter and load buffer.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         base_q <= '0;
         row_q  <= '0;
         line_q <= '0;
         load_q <= 1'b0;
      end else begin
         if (state_q == S_IDLE && (start_store || start_load)) begin
            cnt_q  <= '0;
            base_q <= base_addr & ~ADDR_W'(3);
            row_q  <= row_index;
            line_q <= store_line;
            load_q <= ~start_store;
         end else if (xfer_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (state_q == S_LOAD) line_q[cnt_q*XLEN +: XLEN] <= mem_rdata;
         end
      end
   end

   // Output decode; everything except stall depends only on registered state.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mat_wr_en    = 1'b0;
      mat_wr_index = '0;
      mat_wr_line  = '0;
      done         = 1'b0;
      busy         = (state_q != S_IDLE);
      stall        = active_c || (state_q == S_IDLE && (start_store || start_load));
      case (state_q)
         S_STORE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = base_q + ADDR_W'({cnt_q, 2'b00});
            mem_wdata = line_q[cnt_q*XLEN +: XLEN];
         end
         S_LOAD: begin
            mem_req  = 1'b1;
            mem_addr = base_q + ADDR_W'({cnt_q, 2'b00});
         end
         S_DONE: begin
            done = 1'b1;
            if (load_q) begin
               mat_wr_en    = 1'b1;
               mat_wr_index = row_q;
               mat_wr_line  = line_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_matrix_seq.sv
// Randomized self-checking bench for mem_matrix_seq.
module tb_mem_matrix_seq;

   localparam int unsigned XLEN    = 32;
   localparam int unsigned MAT_DIM = 4;
   localparam int unsigned ADDR_W  = 32;
   localparam int unsigned LINE_W  = MAT_DIM * XLEN;

   logic              clk = 1'b0;
   logic              rst;
   logic              start_store;
   logic              start_load;
   logic [ADDR_W-1:0] base_addr;
   logic [1:0]        row_index;
   logic [LINE_W-1:0] store_line;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic              mem_ready;
   logic [XLEN-1:0]   mem_rdata;
   logic              stall;
   logic              busy;
   logic              mat_wr_en;
   logic [1:0]        mat_wr_index;
   logic [LINE_W-1:0] mat_wr_line;
   logic              done;

   int n_cmp = 0;
   int n_err = 0;

   mem_matrix_seq #(.XLEN(XLEN), .MAT_DIM(MAT_DIM), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .start_store(start_store), .start_load(start_load),
      .base_addr(base_addr), .row_index(row_index), .store_line(store_line),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .stall(stall), .busy(busy),
      .mat_wr_en(mat_wr_en), .mat_wr_index(mat_wr_index), .mat_wr_line(mat_wr_line),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One transaction: expected address list and latency come from the row rules,
   // the memory side is emulated here with optional wait states.
   task automatic run_txn(input bit do_store, input bit do_load, input logic [31:0] base,
                          input logic [1:0] row, input logic [LINE_W-1:0] line,
                          input bit rnd_ready, input int wait_word, input int wait_len,
                          input bit rnd_data, input bit hold);
      logic [31:0]       exp_addr[$];
      logic [LINE_W-1:0] exp_line = '0;
      bit                is_store = do_store;
      bit                r;
      bit                fin = 1'b0;
      int                accs = 0;
      int                waited = 0;
      int                nwait = 0;
      int                cyc = 0;
      for (int k = 0; k < int'(MAT_DIM); k++)
         exp_addr.push_back((base & 32'hFFFF_FFFC) + 32'(4 * k));
      @(negedge clk);
      start_store = do_store;
      start_load  = do_load;
      base_addr   = base;
      row_index   = row;
      store_line  = line;
      mem_ready   = 1'b0;
      #1;
      chk("stall_on_start", stall, 1);
      chk("busy_in_idle", busy, 0);
      while (!fin && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (!hold) begin
            start_store = 1'b0;
            start_load  = 1'b0;
         end
         #1;
         chk("busy", busy, 1);
         if (accs < int'(MAT_DIM)) begin
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, is_store);
            chk("mem_addr", mem_addr, exp_addr[accs]);
            if (is_store) chk("mem_wdata", mem_wdata, line[accs*XLEN +: XLEN]);
            chk("stall_xfer", stall, 1);
            chk("done_early", done, 0);
            chk("wr_en_early", mat_wr_en, 0);
            r = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (accs == wait_word && waited < wait_len) begin
               r = 1'b0;
               waited++;
            end
            if (!r) nwait++;
            mem_ready = r;
            mem_rdata = rnd_data ? $urandom : 32'(32'hA0 + accs);
            if (r) begin
               exp_line[accs*XLEN +: XLEN] = mem_rdata;
               accs++;
            end
         end else begin
            mem_ready = 1'b0;
            chk("done", done, 1);
            chk("mat_wr_en", mat_wr_en, !is_store);
            if (!is_store) begin
               chk("mat_wr_index", mat_wr_index, row);
               chk("mat_wr_line", mat_wr_line, exp_line);
            end
            chk("mem_req_done", mem_req, 0);
            chk("stall_done", stall, 0);
            chk("latency", cyc, MAT_DIM + 1 + nwait);
            fin = 1'b1;
         end
      end
      if (!fin) chk("timeout", 0, 1);
      // Starts may still be high across the DONE->IDLE edge; no retrigger allowed.
      @(negedge clk);
      start_store = 1'b0;
      start_load  = 1'b0;
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_mem_req", mem_req, 0);
      chk("idle_done", done, 0);
      chk("idle_wr_en", mat_wr_en, 0);
      @(negedge clk);
      chk("idle2_busy", busy, 0);
      chk("idle2_mem_req", mem_req, 0);
   endtask

   initial begin
      logic [LINE_W-1:0] rl;
      int                op;
      rst = 1'b1;
      start_store = 1'b0;
      start_load  = 1'b0;
      base_addr   = '0;
      row_index   = '0;
      store_line  = '0;
      mem_ready   = 1'b0;
      mem_rdata   = '0;
      repeat (2) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_stall", stall, 0);
      chk("rst_wr_en", mat_wr_en, 0);
      chk("rst_wr_index", mat_wr_index, 0);
      chk("rst_wr_line", mat_wr_line, 0);
      chk("rst_done", done, 0);
      rst = 1'b0;

      run_txn(1, 0, 32'h100, 2'd2, {32'h44, 32'h33, 32'h22, 32'h11}, 0, -1, 0, 0, 0);
      run_txn(0, 1, 32'h200, 2'd1, '0, 0, -1, 0, 0, 0);
      run_txn(0, 1, 32'h200, 2'd1, '0, 0, 2, 3, 0, 0);
      run_txn(1, 1, 32'hFFFF_FFF8, 2'd0, {32'hD, 32'hC, 32'hB, 32'hA}, 0, -1, 0, 0, 0);
      run_txn(1, 0, 32'h103, 2'd3, {32'h4, 32'h3, 32'h2, 32'h1}, 0, -1, 0, 0, 1);
      run_txn(0, 1, 32'h103, 2'd2, '0, 0, -1, 0, 1, 1);

      // Reset in the middle of a load after two words have completed.
      @(negedge clk);
      start_load = 1'b1;
      base_addr  = 32'h300;
      row_index  = 2'd3;
      @(negedge clk);
      start_load = 1'b0;
      mem_ready  = 1'b1;
      mem_rdata  = 32'h55;
      @(negedge clk);
      mem_rdata  = 32'h66;
      @(negedge clk);
      mem_ready  = 1'b0;
      rst        = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_mem_req", mem_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_stall", stall, 0);
      chk("abort_done", done, 0);
      chk("abort_wr_en", mat_wr_en, 0);
      @(negedge clk);
      chk("abort_done2", done, 0);
      chk("abort_wr_en2", mat_wr_en, 0);

      for (int i = 0; i < 30; i++) begin
         rl = {$urandom, $urandom, $urandom, $urandom};
         op = int'($urandom_range(0, 2));
         run_txn(op != 1, op != 0, $urandom, 2'($urandom), rl, 1, -1, 0, 1, bit'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
